timer_run_ctrl: RTL and testbench

Run/pause/clear sequencer for the stopwatch datapath. Owns two counter instances: a count-up timer and a count-down timer.
- Debounces the raw start and clear buttons.
- Generates the 1 Hz count-enable tick and the single-cycle clear pulses.
- Selects which timer drives the display bus.
- Raises an alarm when the count-down reaches zero.

---
 rtl/timer_run_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_timer_run_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/timer_run_ctrl.sv
// Stopwatch run/pause/clear sequencer: button conditioning, 1 Hz prescaler, run FSM, display mux.
// Build option ALARM_BLINK_EN: alarm toggles on every tick while in DONE instead of holding steady.
module timer_run_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        sw_mode,
    input  logic [23:0] up_time,
    input  logic [23:0] down_time,
    input  logic        down_zero,
    output logic        tick_en_up,
    output logic        tick_en_down,
    output logic        clr_up,
    output logic        clr_down,
    output logic [23:0] disp_bus,
    output logic [1:0]  state,
    output logic        alarm
);

    localparam int PRE   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic             start_s1_q, start_s2_q;
    logic             clear_s1_q, clear_s2_q;
    logic             mode_s1_q, mode_s2_q;

    logic             start_acc_q, start_acc_d;
    logic             clear_acc_q, clear_acc_d;
    logic [DEB_W-1:0] start_cnt_q, start_cnt_d;
    logic [DEB_W-1:0] clear_cnt_q, clear_cnt_d;
    logic             start_press_q, start_press_d;
    logic             clear_press_q, clear_press_d;

    state_t           state_q;
    logic             alarm_q;
    logic             clr_up_q, clr_down_q;
    logic             mode_q;
    logic [PRE_W-1:0] pre_q;
    logic             tick_state;
    logic             tick;

    // Accepted level flips only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        start_acc_d = start_acc_q;
        start_cnt_d = '0;
        if (start_s2_q != start_acc_q) begin
            if (start_cnt_q == DEB_LAST) begin
                start_acc_d = start_s2_q;
            end else begin
                start_cnt_d = start_cnt_q + DEB_W'(1);
            end
        end

        clear_acc_d = clear_acc_q;
        clear_cnt_d = '0;
        if (clear_s2_q != clear_acc_q) begin
            if (clear_cnt_q == DEB_LAST) begin
                clear_acc_d = clear_s2_q;
            end else begin
                clear_cnt_d = clear_cnt_q + DEB_W'(1);
            end
        end

        start_press_d = start_acc_d & ~start_acc_q;
        clear_press_d = clear_acc_d & ~clear_acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_s1_q    <= 1'b0;
            start_s2_q    <= 1'b0;
            clear_s1_q    <= 1'b0;
            clear_s2_q    <= 1'b0;
            mode_s1_q     <= 1'b0;
            mode_s2_q     <= 1'b0;
            start_acc_q   <= 1'b0;
            clear_acc_q   <= 1'b0;
            start_cnt_q   <= '0;
            clear_cnt_q   <= '0;
            start_press_q <= 1'b0;
            clear_press_q <= 1'b0;
        end else begin
            start_s1_q    <= btn_start;
            start_s2_q    <= start_s1_q;
            clear_s1_q    <= btn_clear;
            clear_s2_q    <= clear_s1_q;
            mode_s1_q     <= sw_mode;
            mode_s2_q     <= mode_s1_q;
            start_acc_q   <= start_acc_d;
            clear_acc_q   <= clear_acc_d;
            start_cnt_q   <= start_cnt_d;
            clear_cnt_q   <= clear_cnt_d;
            start_press_q <= start_press_d;
            clear_press_q <= clear_press_d;
        end
    end

`ifdef ALARM_BLINK_EN
    assign tick_state = (state_q == S_RUN) || (state_q == S_DONE);
`else
    assign tick_state = (state_q == S_RUN);
`endif
    assign tick = tick_state && (pre_q == PRE_LAST);

    // Clear has top priority; inside RUN, expiry outranks a start press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            alarm_q    <= 1'b0;
            clr_up_q   <= 1'b0;
            clr_down_q <= 1'b0;
            mode_q     <= 1'b0;
            pre_q      <= '0;
        end else begin
            clr_up_q   <= 1'b0;
            clr_down_q <= 1'b0;
            if (state_q == S_IDLE || state_q == S_PAUSE) begin
                mode_q <= mode_s2_q;
            end
            if (clear_press_q) begin
                state_q <= S_IDLE;
                alarm_q <= 1'b0;
                pre_q   <= '0;
                if (mode_q) begin
                    clr_down_q <= 1'b1;
                end else begin
                    clr_up_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        pre_q <= '0;
                        if (start_press_q && !(mode_q && down_zero)) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        pre_q <= tick ? '0 : pre_q + PRE_W'(1);
                        if (tick && mode_q && down_zero) begin
                            state_q <= S_DONE;
                            alarm_q <= 1'b1;
                        end else if (start_press_q) begin
                            state_q <= S_PAUSE;
                        end
                    end
                    S_PAUSE: begin
                        if (start_press_q) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        if (start_press_q) begin
                            state_q <= S_IDLE;
                            alarm_q <= 1'b0;
                            pre_q   <= '0;
                        end else begin
`ifdef ALARM_BLINK_EN
                            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
                            if (tick) begin
                                alarm_q <= ~alarm_q;
                            end
`else
                            pre_q <= '0;
`endif
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tick_en_up   = tick & ~mode_q;
    assign tick_en_down = tick & mode_q & ~down_zero;
    assign clr_up       = clr_up_q;
    assign clr_down     = clr_down_q;
    assign disp_bus     = mode_q ? down_time : up_time;
    assign state        = state_q;
    assign alarm        = alarm_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Directed bench for timer_run_ctrl (PRE = 10, DEB_CYCLES = 3) with a tick scoreboard.
module tb_timer_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic        sw_mode = 1'b0;
    logic [23:0] up_time = 24'h010203;
    logic [23:0] down_time = 24'h000005;
    logic        down_zero = 1'b0;
    logic        tick_en_up, tick_en_down, clr_up, clr_down, alarm;
    logic [23:0] disp_bus;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int base;
    logic mon_en = 1'b0;
    logic [33:0] exp_q[$];

    timer_run_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DEB_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
        .sw_mode(sw_mode), .up_time(up_time), .down_time(down_time),
        .down_zero(down_zero), .tick_en_up(tick_en_up), .tick_en_down(tick_en_down),
        .clr_up(clr_up), .clr_down(clr_down), .disp_bus(disp_bus),
        .state(state), .alarm(alarm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_tick(input int c, input logic up);
        logic [31:0] cc;
        cc = c;
        exp_q.push_back({cc, up, ~up});
    endtask

    // Every tick enable is matched against the next scheduled tick; late entries count as missed.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] cc;
            logic [33:0] ex;
            cc = cyc;
            if (exp_q.size() > 0 && exp_q[0][33:2] < cc) begin
                ex = exp_q.pop_front();
                chk("tick_missed", {30'd0, cc, tick_en_up, tick_en_down}, {30'd0, ex});
            end
            if (tick_en_up || tick_en_down) begin
                if (exp_q.size() > 0) ex = exp_q.pop_front();
                else ex = {cc, 2'b00};
                chk("tick_event", {30'd0, cc, tick_en_up, tick_en_down}, {30'd0, ex});
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_outs", {tick_en_up, tick_en_down, clr_up, clr_down, alarm}, 0);
        chk("rst_disp", disp_bus, 24'h010203);
        rst = 1'b1;
        mon_en = 1'b1;
        to_cycle(cyc + 2);

        // Bounce: single-cycle toggles never accepted
        base = cyc;
        btn_start = 1'b1; to_cycle(base + 1);
        btn_start = 1'b0; to_cycle(base + 2);
        btn_start = 1'b1; to_cycle(base + 3);
        btn_start = 1'b0;
        to_cycle(base + 6);  chk("bounce_s6", state, 0);
        to_cycle(base + 12); chk("bounce_s12", state, 0);

        // Start held 10 cycles; ticks every 10 cycles
        base = cyc;
        btn_start = 1'b1;
        push_tick(base + 15, 1'b1);
        push_tick(base + 25, 1'b1);
        push_tick(base + 35, 1'b1);
        to_cycle(base + 5);  chk("start_pulse_idle", state, 0);
        to_cycle(base + 6);  chk("start_run", state, 1);
        to_cycle(base + 10); btn_start = 1'b0;
        // Pause with prescaler at 4, resume: 6 more cycles to tick
        to_cycle(base + 34); btn_start = 1'b1;
        to_cycle(base + 39); btn_start = 1'b0; chk("pause_pre", state, 1);
        to_cycle(base + 40); chk("pause_state", state, 2);
        to_cycle(base + 48); chk("pause_hold", state, 2);
        to_cycle(base + 50); btn_start = 1'b1; push_tick(base + 61, 1'b1);
        to_cycle(base + 55); btn_start = 1'b0; chk("resume_pre", state, 2);
        to_cycle(base + 56); chk("resume_run", state, 1);
        // Start and clear accepted together: clear wins
        to_cycle(base + 62); btn_start = 1'b1; btn_clear = 1'b1;
        to_cycle(base + 67); btn_start = 1'b0; btn_clear = 1'b0;
        chk("both_pre_state", state, 1);
        chk("both_pre_clr", {clr_up, clr_down}, 2'b00);
        to_cycle(base + 68);
        chk("both_state", state, 0);
        chk("both_clr", {clr_up, clr_down}, 2'b10);
        to_cycle(base + 69);
        chk("both_clr_end", {clr_up, clr_down}, 2'b00);
        chk("both_no_pause", state, 0);
        to_cycle(base + 76);

        // Mode latch / display mux
        base = cyc;
        up_time = 24'h0A0B0C; down_time = 24'h000002;
        btn_start = 1'b1; push_tick(base + 15, 1'b1);
        to_cycle(base + 5);  btn_start = 1'b0;
        to_cycle(base + 7);  sw_mode = 1'b1;
        to_cycle(base + 12); chk("run_disp_frozen", disp_bus, 24'h0A0B0C);
        to_cycle(base + 16); btn_start = 1'b1;
        to_cycle(base + 21); btn_start = 1'b0;
        to_cycle(base + 22); chk("m_pause", state, 2); chk("m_disp_up", disp_bus, 24'h0A0B0C);
        to_cycle(base + 23); chk("m_disp_down", disp_bus, 24'h000002);
        to_cycle(base + 25); sw_mode = 1'b0;
        to_cycle(base + 27); chk("m_sync_lat", disp_bus, 24'h000002);
        to_cycle(base + 28); chk("m_disp_back", disp_bus, 24'h0A0B0C);
        to_cycle(base + 30); btn_clear = 1'b1;
        to_cycle(base + 35); btn_clear = 1'b0;
        to_cycle(base + 36); chk("m_clr_state", state, 0); chk("m_clr", {clr_up, clr_down}, 2'b10);
        to_cycle(base + 40);

        // Count-down to expiry, alarm, acknowledge
        base = cyc;
        sw_mode = 1'b1; down_zero = 1'b0; down_time = 24'h000002;
        to_cycle(base + 4);  btn_start = 1'b1;
        push_tick(base + 19, 1'b0);
        push_tick(base + 29, 1'b0);
        to_cycle(base + 9);  btn_start = 1'b0;
        to_cycle(base + 10); chk("cd_run", state, 1);
        to_cycle(base + 30); #1; down_zero = 1'b1; down_time = 24'h000000;
        to_cycle(base + 39); chk("cd_pre_done", {state, alarm}, {2'd1, 1'b0});
        to_cycle(base + 40); chk("cd_done", {state, alarm}, {2'd3, 1'b1});
        to_cycle(base + 49); chk("alarm_a", alarm, 1);
`ifdef ALARM_BLINK_EN
        to_cycle(base + 50); chk("alarm_b", alarm, 0);
`else
        to_cycle(base + 50); chk("alarm_b", alarm, 1);
`endif
        to_cycle(base + 60); chk("alarm_c", alarm, 1);
        to_cycle(base + 61); btn_start = 1'b1;
        to_cycle(base + 66); btn_start = 1'b0;
        to_cycle(base + 67); chk("ack_idle", {state, alarm}, {2'd0, 1'b0});
        // Start refused while count-down already reads zero
        to_cycle(base + 70); btn_start = 1'b1;
        to_cycle(base + 75); btn_start = 1'b0;
        to_cycle(base + 76); chk("zero_guard", state, 0);
        to_cycle(base + 80); btn_clear = 1'b1;
        to_cycle(base + 85); btn_clear = 1'b0;
        to_cycle(base + 86); chk("clr_down_pulse", {clr_up, clr_down}, 2'b01);
        to_cycle(base + 87); chk("clr_down_end", {clr_up, clr_down}, 2'b00);

        // Asynchronous reset mid-RUN
        base = cyc;
        sw_mode = 1'b0; down_zero = 1'b0;
        to_cycle(base + 4);  btn_start = 1'b1;
        to_cycle(base + 9);  btn_start = 1'b0;
        to_cycle(base + 14); chk("rr_run", state, 1);
        rst = 1'b0; #1;
        chk("rr_state", state, 0);
        chk("rr_outs", {clr_up, clr_down, alarm, tick_en_up}, 0);
        to_cycle(base + 16); rst = 1'b1;
        to_cycle(base + 20); chk("rr_after", state, 0);

        to_cycle(cyc + 5);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
